// File: rtl/baud_pkg.sv
// Shared definitions for the baud rate engine.
// calc_inc     : rounded phase increment for a given clock, baud, oversample and
//                accumulator width (64-bit arithmetic so ACC_W up to 30 cannot overflow)
// clog2_min1   : ceil(log2(n)) but never less than 1, for counter widths
// BAUD_*       : default parameter values for the engine
package baud_pkg;

  localparam int unsigned BAUD_CLK_FREQ     = 100_000_000;
  localparam int unsigned BAUD_DEFAULT_BAUD = 9600;
  localparam int unsigned BAUD_OVERSAMPLE   = 16;
  localparam int unsigned BAUD_ACC_W        = 24;

  function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input longint unsigned os,
                                               input longint unsigned acc_w);
    longint unsigned num;
    num = baud * os * (64'd1 << acc_w);
    return (num + clk_freq / 2) / clk_freq;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_phase_cnt.sv
// Modulo-OVERSAMPLE oversample phase counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : force phase to 0 (idle or bit-edge re-align), suppresses bit tick
//   half_i       : force phase to OVERSAMPLE/2 (mid-bit re-align), suppresses bit tick
//   adv_i        : one oversample tick occurred this cycle
//   bit_tick_o   : registered pulse when the phase wraps to 0
//   os_phase_o   : current phase index 0..OVERSAMPLE-1
module baud_phase_cnt #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PH_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            half_i,
  input  logic            adv_i,
  output logic            bit_tick_o,
  output logic [PH_W-1:0] os_phase_o
);

  localparam logic [PH_W-1:0] LAST = PH_W'(OVERSAMPLE - 1);
  // With OVERSAMPLE=1 this is 0, so a half re-align degenerates to a full one.
  localparam logic [PH_W-1:0] HALF = PH_W'(OVERSAMPLE / 2);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            bit_q, bit_d;

  always_comb begin
    phase_d = phase_q;
    bit_d   = 1'b0;
    if (clr_i) begin
      phase_d = '0;
    end else if (half_i) begin
      phase_d = HALF;
    end else if (adv_i) begin
      if (phase_q == LAST) begin
        phase_d = '0;
        bit_d   = 1'b1;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      bit_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  assign bit_tick_o = bit_q;
  assign os_phase_o = phase_q;

endmodule

// File: rtl/baud_rate_engine.sv
// Fractional-N baud tick generator: a phase accumulator produces the oversample
// tick on carry, and a modulo-OVERSAMPLE counter derives the bit tick.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable       : run; low holds accumulator/phase at 0 and applies any pending increment
//   inc_load     : strobe to capture inc_value (non-zero only) into the shadow register
//   inc_value    : new increment
//   sync         : re-align to a bit edge (next bit tick after OVERSAMPLE os ticks)
//   sync_half    : re-align to mid-bit (next bit tick after ceil(OVERSAMPLE/2) os ticks)
//   os_tick      : oversample tick pulse
//   bit_tick     : bit tick pulse, coincident with os_tick
//   os_phase     : oversample index within the bit
//   inc_pending  : shadow increment waiting for the next carry
module baud_rate_engine
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = BAUD_CLK_FREQ,
  parameter int unsigned DEFAULT_BAUD = BAUD_DEFAULT_BAUD,
  parameter int unsigned OVERSAMPLE   = BAUD_OVERSAMPLE,
  parameter int unsigned ACC_W        = BAUD_ACC_W,
  localparam int unsigned PH_W        = clog2_min1(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] inc_value,
  input  logic             sync,
  input  logic             sync_half,
  output logic             os_tick,
  output logic             bit_tick,
  output logic [PH_W-1:0]  os_phase,
  output logic             inc_pending
);

  localparam longint unsigned DEFAULT_INC64 =
    calc_inc(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, ACC_W);

  if (ACC_W < 16 || ACC_W > 30) begin : g_bad_acc_w
    $error("baud_rate_engine: ACC_W must be within 16..30");
  end
  if (OVERSAMPLE == 0) begin : g_bad_os
    $error("baud_rate_engine: OVERSAMPLE must be at least 1");
  end
  if (DEFAULT_INC64 == 0 || DEFAULT_INC64 >= (64'd1 << ACC_W)) begin : g_bad_inc
    $error("baud_rate_engine: default increment out of range for ACC_W");
  end

  localparam logic [ACC_W-1:0] DEFAULT_INC = DEFAULT_INC64[ACC_W-1:0];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             os_q, os_d;
  logic [ACC_W:0]   sum;
  logic             apply;
  logic             phase_clr, phase_half;

  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d = '0;
    os_d  = 1'b0;
    // Idle and both re-align requests clear the accumulator; the carry of a
    // re-align cycle is thrown away so the new bit starts cleanly.
    if (enable && !sync && !sync_half) begin
      acc_d = sum[ACC_W-1:0];
      os_d  = sum[ACC_W];
    end

    // Swap increments only on a carry so no os period mixes two rates.
    apply    = pend_q && (!enable || os_d);
    inc_d    = apply ? shadow_q : inc_q;
    pend_d   = pend_q && !apply;
    shadow_d = shadow_q;
    if (inc_load && (inc_value != '0)) begin
      shadow_d = inc_value;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      inc_q    <= DEFAULT_INC;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      os_q     <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      os_q     <= os_d;
    end
  end

  // sync has priority over sync_half.
  assign phase_clr  = !enable || sync;
  assign phase_half = enable && !sync && sync_half;

  baud_phase_cnt #(
    .OVERSAMPLE (OVERSAMPLE),
    .PH_W       (PH_W)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (phase_clr),
    .half_i     (phase_half),
    .adv_i      (os_d),
    .bit_tick_o (bit_tick),
    .os_phase_o (os_phase)
  );

  assign os_tick     = os_q;
  assign inc_pending = pend_q;

endmodule
